// File: rtl/nlms_echo_canceller.sv
// NLMS adaptive echo canceller: TAPS-tap FIR estimates the echo of the far-end
// signal in the near-end signal. A single time-shared MAC is used. The coefficient
// update is normalised by the input energy via a shift, so no divider is needed.
module nlms_echo_canceller #(
  parameter  int TAPS     = 16,
  parameter  int DATA_W   = 16,
  parameter  int COEF_W   = 18,
  parameter  int MU_SHIFT = 2,
  parameter  int GAMMA    = 16,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic              clk_operation,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] far_sample,
  input  logic [DATA_W-1:0] near_sample,
  input  logic              adapt_en,
  input  logic              coef_clear,
  output logic              out_valid,
  output logic [DATA_W-1:0] err_out,
  output logic [DATA_W-1:0] echo_est,
  output logic              busy,
  input  logic [AW-1:0]     coef_rd_addr,
  output logic [COEF_W-1:0] coef_rd_data
);

  localparam int MW  = DATA_W + COEF_W;   // one MAC product
  localparam int ACW = MW + AW;           // accumulator, no overflow over TAPS products
  localparam int SQW = 2 * DATA_W;        // one squared sample
  localparam int PEW = SQW + AW;          // energy over the delay line
  localparam int PGW = PEW + 1;           // energy plus regulariser
  localparam int KW  = $clog2(PGW) + 1;   // leading-one index
  localparam int UW  = SQW + COEF_W;      // update path, wide enough that nothing wraps
  localparam int EW  = DATA_W + 1;        // d - y before saturation

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILTER = 3'd1;
  localparam logic [2:0] S_ERROR  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;

  localparam logic [AW-1:0]     LAST  = AW'(TAPS - 1);
  localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [COEF_W-1:0] C_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic [COEF_W-1:0] C_MIN = {1'b1, {(COEF_W-1){1'b0}}};

  logic [2:0]               state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [ACW-1:0]    acc_q, acc_d;
  logic [PEW-1:0]           p_q, p_d;
  logic signed [DATA_W-1:0] near_q, near_d;
  logic                     adapt_q, adapt_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        err_out_q, err_out_d;
  logic [DATA_W-1:0]        echo_est_q, echo_est_d;
  logic [COEF_W-1:0]        coef_rd_data_q, coef_rd_data_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] w_q [TAPS];
  logic signed [COEF_W-1:0] w_d [TAPS];

  logic signed [SQW-1:0]    far_sq, old_sq;
  logic signed [MW-1:0]     mac_prod;
  logic signed [ACW-1:0]    acc_sh;
  logic signed [DATA_W-1:0] y_sat, e_sat;
  logic signed [EW-1:0]     diff;
  logic [PGW-1:0]           pg;
  logic [KW-1:0]            k_calc;
  logic signed [UW-1:0]     up_prod, up_step, up_sum;
  logic signed [COEF_W-1:0] w_new;

  assign in_ready     = (state_q == S_IDLE) && !coef_clear;
  assign busy         = ~in_ready;
  assign out_valid    = out_valid_q;
  assign err_out      = err_out_q;
  assign echo_est     = echo_est_q;
  assign coef_rd_data = coef_rd_data_q;

  // Datapath: energy terms, MAC product, saturated y/e, leading-one index, one tap update
  always_comb begin
    far_sq   = SQW'($signed(far_sample)) * SQW'($signed(far_sample));
    old_sq   = SQW'(x_q[TAPS-1]) * SQW'(x_q[TAPS-1]);
    mac_prod = MW'(x_q[idx_q]) * MW'(w_q[idx_q]);

    // y = acc >>> (COEF_W-2), clamped when the discarded upper bits are not a sign extension
    acc_sh = acc_q >>> (COEF_W - 2);
    if ((&acc_sh[ACW-1:DATA_W-1]) || !(|acc_sh[ACW-1:DATA_W-1])) y_sat = acc_sh[DATA_W-1:0];
    else if (acc_sh[ACW-1])                                      y_sat = D_MIN;
    else                                                         y_sat = D_MAX;

    diff = EW'(near_q) - EW'(y_sat);
    if (diff[EW-1] == diff[EW-2]) e_sat = diff[DATA_W-1:0];
    else if (diff[EW-1])          e_sat = D_MIN;
    else                          e_sat = D_MAX;

    // GAMMA >= 1 keeps pg nonzero, so a leading one always exists
    pg     = PGW'(p_q) + PGW'(GAMMA);
    k_calc = '0;
    for (int b = 0; b < PGW; b++) begin
      if (pg[b]) k_calc = KW'(b);
    end

    up_prod = UW'($signed(err_out_q)) * UW'(x_q[idx_q]);
    up_step = (up_prod <<< (COEF_W - 2)) >>> (k_q + MU_SHIFT);
    up_sum  = up_step + UW'(w_q[idx_q]);
    if ((&up_sum[UW-1:COEF_W-1]) || !(|up_sum[UW-1:COEF_W-1])) w_new = up_sum[COEF_W-1:0];
    else if (up_sum[UW-1])                                     w_new = C_MIN;
    else                                                       w_new = C_MAX;
  end

  // Next-state logic for the sequencer and all architectural state
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    p_d            = p_q;
    near_d         = near_q;
    adapt_d        = adapt_q;
    k_d            = k_q;
    out_valid_d    = 1'b0;
    err_out_d      = err_out_q;
    echo_est_d     = echo_est_q;
    x_d            = x_q;
    w_d            = w_q;
    coef_rd_data_d = w_q[coef_rd_addr];
    case (state_q)
      S_IDLE: begin
        if (coef_clear) begin
          for (int i = 0; i < TAPS; i++) begin
            x_d[i] = '0;
            w_d[i] = '0;
          end
          p_d = '0;
        end else if (in_valid) begin
          x_d[0] = $signed(far_sample);
          for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          near_d  = $signed(near_sample);
          adapt_d = adapt_en;
          // Running energy is exact: add the new square, drop the one leaving the line
          p_d     = p_q + PEW'(far_sq) - PEW'(old_sq);
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_FILTER;
        end
      end
      S_FILTER: begin
        acc_d = acc_q + ACW'(mac_prod);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_ERROR;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_ERROR: begin
        echo_est_d  = y_sat;
        err_out_d   = e_sat;
        k_d         = k_calc;
        out_valid_d = 1'b1;
        idx_d       = '0;
        state_d     = adapt_q ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        w_d[idx_q] = w_new;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear; a reset drops any in-flight sample
  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      p_q            <= '0;
      near_q         <= '0;
      adapt_q        <= 1'b0;
      k_q            <= '0;
      out_valid_q    <= 1'b0;
      err_out_q      <= '0;
      echo_est_q     <= '0;
      coef_rd_data_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      p_q            <= p_d;
      near_q         <= near_d;
      adapt_q        <= adapt_d;
      k_q            <= k_d;
      out_valid_q    <= out_valid_d;
      err_out_q      <= err_out_d;
      echo_est_q     <= echo_est_d;
      coef_rd_data_q <= coef_rd_data_d;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule
